// File: rtl/vend_credit_ctrl_if.sv
// vend_credit_ctrl_if: coin, cancel and dispenser signals between the vending controller and its environment
// master drives the coin sensors, cancel and dispense_ack; slave (the controller) drives
// the credit code a3..a0, dispense, change_nickel, coin_reject and busy.
interface vend_credit_ctrl_if;
  logic nickel;
  logic dime;
  logic cancel;
  logic dispense_ack;
  logic a3;
  logic a2;
  logic a1;
  logic a0;
  logic dispense;
  logic change_nickel;
  logic coin_reject;
  logic busy;
  modport master (
    output nickel, dime, cancel, dispense_ack,
    input  a3, a2, a1, a0, dispense, change_nickel, coin_reject, busy
  );
  modport slave (
    input  nickel, dime, cancel, dispense_ack,
    output a3, a2, a1, a0, dispense, change_nickel, coin_reject, busy
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: accumulates nickel/dime credit, requests a dispense at PRICE_UNITS, pays change one nickel per cycle
// clk/rst_n: clock and asynchronous active-low reset.
// bus (slave): nickel/dime/cancel act on rising edges; dispense_ack is sampled in VEND only;
// a3..a0 carry the registered credit; dispense, change_nickel, coin_reject and busy are registered.
module vend_credit_ctrl #(
  parameter int PRICE_UNITS = 5,
  parameter int MAX_CREDIT  = 8
) (
  input logic          clk,
  input logic          rst_n,
  vend_credit_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ACCEPT = 2'd0, VEND = 2'd1, CHANGE = 2'd2} state_t;
  localparam logic [4:0] PRICE = 5'(PRICE_UNITS);
  localparam logic [4:0] MAXC  = 5'(MAX_CREDIT);
  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       nickel_q, dime_q, cancel_q;
  logic       dispense_q, change_nickel_q, coin_reject_q, busy_q;
  logic       coin_reject_d;
  logic       ev_nickel, ev_dime, ev_cancel, coin_ev;
  logic [4:0] coin_sum;
  assign ev_nickel = bus.nickel & ~nickel_q;
  assign ev_dime   = bus.dime & ~dime_q;
  assign ev_cancel = bus.cancel & ~cancel_q;
  assign coin_ev   = ev_nickel | ev_dime;
  assign coin_sum  = {1'b0, credit_q} + (ev_dime ? 5'd2 : 5'd1);
  // Every coin event is refused unless ACCEPT explicitly takes it below.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = coin_ev;
    case (state_q)
      ACCEPT: begin
        if (ev_cancel && credit_q != 4'd0) state_d = CHANGE;
        else if (coin_ev && !(ev_nickel && ev_dime) && coin_sum <= MAXC) begin
          coin_reject_d = 1'b0;
          credit_d      = coin_sum[3:0];
          state_d       = coin_sum >= PRICE ? VEND : ACCEPT;
        end
      end
      VEND: if (bus.dispense_ack) begin
        credit_d = credit_q >= PRICE[3:0] ? credit_q - PRICE[3:0] : 4'd0;
        state_d  = credit_q > PRICE[3:0] ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        credit_d = credit_q == 4'd0 ? 4'd0 : credit_q - 4'd1;
        state_d  = credit_q > 4'd1 ? CHANGE : ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end
  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ACCEPT;
      credit_q        <= 4'd0;
      nickel_q        <= 1'b0;
      dime_q          <= 1'b0;
      cancel_q        <= 1'b0;
      dispense_q      <= 1'b0;
      change_nickel_q <= 1'b0;
      coin_reject_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      nickel_q        <= bus.nickel;
      dime_q          <= bus.dime;
      cancel_q        <= bus.cancel;
      dispense_q      <= state_d == VEND;
      change_nickel_q <= state_d == CHANGE;
      coin_reject_q   <= coin_reject_d;
      busy_q          <= state_d != ACCEPT;
    end
  end
  assign {bus.a3, bus.a2, bus.a1, bus.a0} = credit_q;
  assign bus.dispense      = dispense_q;
  assign bus.change_nickel = change_nickel_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: scoreboard bench driving a PRICE 5 and a PRICE 8 controller with identical stimulus
module tb_vend_credit_ctrl;
  localparam int MAXC = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic n = 1'b0, d = 1'b0, c = 1'b0, ack = 1'b0;
  logic pn = 1'b0, pd = 1'b0, pc = 1'b0;
  always #5 clk = ~clk;
  vend_credit_ctrl_if b5 ();
  vend_credit_ctrl_if b8 ();
  assign b5.nickel = n;
  assign b5.dime = d;
  assign b5.cancel = c;
  assign b5.dispense_ack = ack;
  assign b8.nickel = n;
  assign b8.dime = d;
  assign b8.cancel = c;
  assign b8.dispense_ack = ack;
  vend_credit_ctrl #(.PRICE_UNITS(5), .MAX_CREDIT(MAXC)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
  vend_credit_ctrl #(.PRICE_UNITS(8), .MAX_CREDIT(MAXC)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  logic [7:0] o5, o8;
  assign o5 = {b5.a3, b5.a2, b5.a1, b5.a0, b5.dispense, b5.change_nickel, b5.coin_reject, b5.busy};
  assign o8 = {b8.a3, b8.a2, b8.a1, b8.a0, b8.dispense, b8.change_nickel, b8.coin_reject, b8.busy};
  int n_chk = 0;
  int n_fail = 0;
  string cur = "init";
  int m_cr[2] = '{0, 0};
  int m_st[2] = '{0, 0};
  int price[2] = '{5, 8};
  logic [7:0] q5[$];
  logic [7:0] q8[$];
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got code=%0d disp=%b chg=%b rej=%b busy=%b, expected code=%0d disp=%b chg=%b rej=%b busy=%b",
               tag, got[7:4], got[3], got[2], got[1], got[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  // Reference: states 0=ACCEPT 1=VEND 2=CHANGE; pushes the outputs expected after the coming edge.
  task automatic model(input int i);
    int cr, st, v;
    logic rej, en, ed, ec, coin;
    logic [3:0] c4;
    cr = m_cr[i];
    st = m_st[i];
    rej = 1'b0;
    en = n && !pn;
    ed = d && !pd;
    ec = c && !pc;
    coin = en || ed;
    if (st == 1) begin
      rej = coin;
      if (ack) begin
        cr = cr - price[i];
        st = (cr > 0) ? 2 : 0;
      end
    end else if (st == 2) begin
      rej = coin;
      cr = cr - 1;
      if (cr == 0) st = 0;
    end else begin
      if (ec && cr > 0) begin
        st = 2;
        rej = coin;
      end else if (en && ed) rej = 1'b1;
      else if (coin) begin
        v = en ? 1 : 2;
        if (cr + v > MAXC) rej = 1'b1;
        else begin
          cr = cr + v;
          if (cr >= price[i]) st = 1;
        end
      end
    end
    m_cr[i] = cr;
    m_st[i] = st;
    c4 = cr[3:0];
    if (i == 0) q5.push_back({c4, st == 1, st == 2, rej, st != 0});
    else q8.push_back({c4, st == 1, st == 2, rej, st != 0});
  endtask
  task automatic step();
    model(0);
    model(1);
    pn = n;
    pd = d;
    pc = c;
    @(posedge clk);
    #1;
    chk({cur, "/p5"}, o5, q5.pop_front());
    chk({cur, "/p8"}, o8, q8.pop_front());
    @(negedge clk);
  endtask
  task automatic cycles(input int k);
    repeat (k) step();
  endtask
  task automatic coin(input bit is_dime);
    if (is_dime) d = 1'b1;
    else n = 1'b1;
    step();
    n = 1'b0;
    d = 1'b0;
    step();
  endtask
  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    n = 1'b0;
    d = 1'b0;
    c = 1'b0;
    ack = 1'b0;
    pn = 1'b0;
    pd = 1'b0;
    pc = 1'b0;
    m_cr = '{0, 0};
    m_st = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    do_reset();
    cur = "reset";
    chk("reset_p5", o5, 8'h00);
    chk("reset_p8", o8, 8'h00);
    cur = "rst_mid_vend";
    repeat (3) coin(1'b1);
    chk("vend_credit6_p5", o5, {4'd6, 1'b1, 1'b0, 1'b0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_p5", o5, 8'h00);
    chk("async_reset_p8", o8, 8'h00);
    m_cr = '{0, 0};
    m_st = '{0, 0};
    pn = 1'b0;
    pd = 1'b0;
    pc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    cur = "nickels";
    do_reset();
    repeat (5) coin(1'b0);
    cycles(3);
    chk("dispense_held_p5", o5, {4'd5, 1'b1, 1'b0, 1'b0, 1'b1});
    ack_pulse();
    cycles(2);
    chk("after_sale_p5", o5, 8'h00);
    cur = "dimes";
    do_reset();
    repeat (3) coin(1'b1);
    cycles(2);
    ack_pulse();
    chk("change_after_ack_p5", o5, {4'd1, 1'b0, 1'b1, 1'b0, 1'b1});
    cycles(2);
    cur = "both_coins";
    do_reset();
    coin(1'b1);
    coin(1'b1);
    n = 1'b1;
    d = 1'b1;
    step();
    chk("both_reject_p8", o8, {4'd4, 1'b0, 1'b0, 1'b1, 1'b0});
    n = 1'b0;
    d = 1'b0;
    step();
    coin(1'b1);
    coin(1'b1);
    chk("vend_at_8_p8", o8, {4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
    ack_pulse();
    cycles(3);
    cur = "overflow";
    do_reset();
    repeat (7) coin(1'b0);
    coin(1'b1);
    chk("overflow_kept7_p8", o8, {4'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    coin(1'b0);
    cycles(2);
    ack_pulse();
    cycles(2);
    cur = "cancel";
    do_reset();
    repeat (3) coin(1'b0);
    c = 1'b1;
    step();
    c = 1'b0;
    d = 1'b1;
    step();
    d = 1'b0;
    cycles(4);
    chk("cancel_done_p5", o5, 8'h00);
    cur = "cancel_zero";
    do_reset();
    c = 1'b1;
    step();
    c = 1'b0;
    step();
    cur = "cancel_coin";
    coin(1'b0);
    coin(1'b0);
    c = 1'b1;
    d = 1'b1;
    step();
    c = 1'b0;
    d = 1'b0;
    cycles(4);
    cur = "held_nickel";
    do_reset();
    n = 1'b1;
    cycles(10);
    chk("held_once_p5", o5, {4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    n = 1'b0;
    step();
    ack_pulse();
    step();
    chk("ack_ignored_p8", o8, {4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
